// File: rtl/router_wrap_idata_fifo.sv
// Show-ahead input flit FIFO behind the router_wrap IDATA flops.
// Returns one registered credit per dequeued flit; sticky overflow flag.
module router_wrap_idata_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  credit_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow_err,
  input  logic                  err_clr
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_credit;
  logic                  r_err;

  logic w_full;
  logic w_out_valid;
  logic w_deq;
  logic w_enq;
  logic w_ovf;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_deq       = w_out_valid & out_ready;
  // A full buffer still accepts a flit when the head leaves this cycle.
  assign w_enq       = in_valid & (~w_full | w_deq);
  assign w_ovf       = in_valid & w_full & ~w_deq;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_credit <= w_deq;
      // Set beats clear so a same-cycle overflow is never lost.
      if (w_ovf) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_valid    = w_out_valid;
  assign out_data     = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign count        = r_count;
  assign credit_out   = r_credit;
  assign overflow_err = r_err;

endmodule

// File: tb/tb_router_wrap_idata_fifo.sv
// Directed bench for router_wrap_idata_fifo.
// Each scenario task drives stimulus and checks expected values inline.
module tb_router_wrap_idata_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        credit_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow_err;
  logic        err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  router_wrap_idata_fifo #(
    .DATA_WIDTH(32),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .credit_out(credit_out),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count),
    .overflow_err(overflow_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    in_data = 'x;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 'x;
    out_ready = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    n_tests++;
    if (count !== 3'd0) begin
      $display("FAIL reset_count: got %0d want 0", count);
      n_fail++;
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", out_valid, out_data);
      n_fail++;
    end
    n_tests++;
    if (credit_out !== 1'b0 || overflow_err !== 1'b0) begin
      $display("FAIL reset_flags: got cr=%b err=%b want 0 0", credit_out, overflow_err);
      n_fail++;
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    in_valid = 1'b1;
    in_data = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    in_data = 'x;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      $display("FAIL single_out: got v=%b d=%h want v=1 d=a5a50001", out_valid, out_data);
      n_fail++;
    end
    n_tests++;
    if (count !== 3'd1 || credit_out !== 1'b0) begin
      $display("FAIL single_cnt: got cnt=%0d cr=%b want 1 0", count, credit_out);
      n_fail++;
    end
    tick();
    n_tests++;
    if (count !== 3'd1 || out_data !== 32'hA5A5_0001) begin
      $display("FAIL single_xsafe: got cnt=%0d d=%h want 1 a5a50001", count, out_data);
      n_fail++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0 || credit_out !== 1'b1 || out_data !== 32'd0) begin
      $display("FAIL single_deq: got cnt=%0d cr=%b d=%h want 0 1 0", count, credit_out, out_data);
      n_fail++;
    end
    tick();
    n_tests++;
    if (credit_out !== 1'b0) begin
      $display("FAIL single_credit_end: got %b want 0", credit_out);
      n_fail++;
    end
  endtask

  task automatic test_fill_drain;
    fill(32'd1);
    n_tests++;
    if (count !== 3'd4 || credit_out !== 1'b0) begin
      $display("FAIL fill_count: got cnt=%0d cr=%b want 4 0", count, credit_out);
      n_fail++;
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        $display("FAIL drain_data%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
        n_fail++;
      end
      tick();
      n_tests++;
      if (credit_out !== 1'b1) begin
        $display("FAIL drain_credit%0d: got %b want 1", i, credit_out);
        n_fail++;
      end
    end
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'd0) begin
      $display("FAIL drain_empty: got cnt=%0d v=%b d=%h want 0 0 0", count, out_valid, out_data);
      n_fail++;
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (credit_out !== 1'b0) begin
      $display("FAIL drain_credit_end: got %b want 0", credit_out);
      n_fail++;
    end
  endtask

  task automatic test_full_rw;
    fill(32'd1);
    in_valid = 1'b1;
    in_data = 32'd5;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = 'x;
    n_tests++;
    if (count !== 3'd4 || overflow_err !== 1'b0 || credit_out !== 1'b1) begin
      $display("FAIL full_rw: got cnt=%0d err=%b cr=%b want 4 0 1", count, overflow_err, credit_out);
      n_fail++;
    end
    for (int i = 2; i <= 5; i++) begin
      n_tests++;
      if (out_data !== 32'(i)) begin
        $display("FAIL full_rw_data%0d: got %h want %h", i, out_data, i);
        n_fail++;
      end
      tick();
    end
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0) begin
      $display("FAIL full_rw_empty: got %0d want 0", count);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_overflow;
    fill(32'd10);
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    in_data = 'x;
    n_tests++;
    if (count !== 3'd4 || overflow_err !== 1'b1) begin
      $display("FAIL ovf_set: got cnt=%0d err=%b want 4 1", count, overflow_err);
      n_fail++;
    end
    tick();
    tick();
    n_tests++;
    if (overflow_err !== 1'b1) begin
      $display("FAIL ovf_sticky: got %b want 1", overflow_err);
      n_fail++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_data !== 32'd10 + 32'(i)) begin
        $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, 10 + i);
        n_fail++;
      end
      tick();
    end
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0 || out_data !== 32'd0 || overflow_err !== 1'b1) begin
      $display("FAIL ovf_after: got cnt=%0d d=%h err=%b want 0 0 1", count, out_data, overflow_err);
      n_fail++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++;
    if (overflow_err !== 1'b0) begin
      $display("FAIL ovf_clear: got %b want 0", overflow_err);
      n_fail++;
    end
    fill(32'd30);
    in_valid = 1'b1;
    in_data = 32'hBEEF;
    err_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    err_clr = 1'b0;
    n_tests++;
    if (overflow_err !== 1'b1 || count !== 3'd4) begin
      $display("FAIL ovf_set_wins: got err=%b cnt=%0d want 1 4", overflow_err, count);
      n_fail++;
    end
    do_reset();
    n_tests++;
    if (overflow_err !== 1'b0 || count !== 3'd0) begin
      $display("FAIL ovf_reset: got err=%b cnt=%0d want 0 0", overflow_err, count);
      n_fail++;
    end
  endtask

  task automatic test_wrap_stream;
    int sent = 0;
    int recv = 0;
    int occ = 0;
    int credits = 0;
    int cyc = 0;
    bit enq;
    bit deq;
    while (recv < 20 && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      deq = (occ != 0) && out_ready;
      enq = (sent < 20) && (occ < 4 || deq);
      in_valid = enq;
      in_data = enq ? 32'(sent) : 'x;
      n_tests++;
      if (out_valid !== (occ != 0)) begin
        $display("FAIL wrap_valid c%0d: got %b want %b", cyc, out_valid, occ != 0);
        n_fail++;
      end
      if (deq) begin
        n_tests++;
        if (out_data !== 32'(recv)) begin
          $display("FAIL wrap_data c%0d: got %h want %h", cyc, out_data, recv);
          n_fail++;
        end
        recv++;
      end
      tick();
      if (enq) sent++;
      occ = occ + (enq ? 1 : 0) - (deq ? 1 : 0);
      if (credit_out === 1'b1) credits++;
      n_tests++;
      if (count !== 3'(occ) || count > 3'd4) begin
        $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, count, occ);
        n_fail++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_data = 'x;
    out_ready = 1'b0;
    n_tests++;
    if (recv != 20) begin
      $display("FAIL wrap_timeout: got %0d flits want 20", recv);
      n_fail++;
    end
    tick();
    if (credit_out === 1'b1) credits++;
    n_tests++;
    if (credits != 20) begin
      $display("FAIL wrap_credits: got %0d want 20", credits);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'd20 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (count !== 3'd3) begin
      $display("FAIL mid_pre: got %0d want 3", count);
      n_fail++;
    end
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || credit_out !== 1'b0 || out_data !== 32'd0) begin
      $display("FAIL mid_reset: got cnt=%0d v=%b cr=%b d=%h want 0 0 0 0", count, out_valid, credit_out, out_data);
      n_fail++;
    end
    in_valid = 1'b1;
    in_data = 32'd7;
    tick();
    in_valid = 1'b0;
    in_data = 'x;
    n_tests++;
    if (out_data !== 32'd7 || count !== 3'd1 || credit_out !== 1'b0) begin
      $display("FAIL mid_write: got d=%h cnt=%0d cr=%b want 7 1 0", out_data, count, credit_out);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_rw();
    test_overflow();
    test_wrap_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_wrap_idata_fifo.md
Name: router_wrap_idata_fifo

Overview:
Input flit buffer directly downstream of the router_wrap slice IDATA flip-flops. It captures each registered IDATA word, qualified by a valid bit, into a small show-ahead FIFO and presents it to the router core with a valid/ready handshake. It returns one credit pulse upstream per flit dequeued, so the upstream sender never overruns the buffer. A sticky error flag records any protocol violation (a write while full).

Parameters:
DATA_WIDTH, 32, width of one IDATA flit in bits
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  a flit is present on in_data this cycle (from the IDATA FF stage)
in_data  input  DATA_WIDTH  registered IDATA flit
credit_out  output  1  one-cycle pulse, one per flit dequeued
out_valid  output  1  head entry is valid
out_data  output  DATA_WIDTH  head entry; forced to 0 when out_valid=0
out_ready  input  1  router core accepts the head this cycle
count  output  CNT_W  current occupancy, 0..DEPTH
overflow_err  output  1  sticky flag: write attempted while full with no dequeue
err_clr  input  1  clears overflow_err

Behaviour:
- Reset is synchronous and active-high. On a clk edge with reset=1:
  - wr_ptr, rd_ptr, count, credit_out, overflow_err all go to 0; out_valid=0, out_data=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored flits and any pending credit pulse. No credits are returned for discarded flits; the upstream re-initialises its counter to DEPTH on the same reset.
- Enqueue:
  - Occurs when in_valid=1 and (count<DEPTH, or count==DEPTH with a dequeue in the same cycle).
  - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Dequeue:
  - Occurs when out_valid=1 and out_ready=1; rd_ptr increments modulo DEPTH.
- Show-ahead output:
  - out_valid = (count!=0).
  - out_data = mem[rd_ptr] when out_valid=1, else 0.
- Latency: a flit enqueued at edge N is visible on out_data with out_valid=1 after edge N, i.e. one cycle. There is no combinational path from in_* to out_*.
- Count update per edge: +1 for enqueue only, -1 for dequeue only, unchanged for both or neither.
- Simultaneous enqueue and dequeue:
  - At count==DEPTH: legal; count stays DEPTH.
  - At count==0: no dequeue is possible (out_valid=0); count becomes 1.
- Overflow:
  - in_valid=1, count==DEPTH and no dequeue: the flit is dropped.
  - Pointers and count are unchanged; overflow_err is set on that edge.
- overflow_err is sticky:
  - Cleared by err_clr=1 or reset.
  - If err_clr and a new overflow occur on the same edge, set wins.
- Credits:
  - credit_out is registered: a dequeue at edge N gives credit_out=1 for the cycle following edge N.
  - Back-to-back dequeues give a continuous high level, one pulse-cycle per flit.
  - Total credits returned always equals total flits dequeued since reset.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished only by count.
- X safety: in_data is ignored when in_valid=0.

Test Plan:
- Reset, then single flit: reset 2 cycles; in_valid=1, in_data=32'hA5A5_0001 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=32'hA5A5_0001, count=1, credit_out=0.
- Fill to full and drain in order: write 1,2,3,4 on consecutive cycles with out_ready=0 -> count=4. Then hold out_ready=1 -> out_data 1,2,3,4 on consecutive cycles; credit_out high for exactly 4 cycles, each lagging its dequeue by 1; count=0 and out_data=0 afterwards.
- Full plus simultaneous read/write: at count=4, in_valid=1 with data 5 and out_ready=1 -> count stays 4, overflow_err=0. Draining then yields 2,3,4,5.
- Overflow: at count=4, in_valid=1 with data 32'hDEAD, out_ready=0 -> count=4, overflow_err=1 and stays 1 for later cycles; 32'hDEAD never appears on out_data. Then err_clr=1 for one cycle -> overflow_err=0.
- Wrap-around streaming: 20 flits with values 0..19 while out_ready toggles 1,0,1,0 -> output order 0..19 with no loss or duplication; credit_out pulse count=20; count never exceeds 4.
- Reset mid-operation: with count=3 and a dequeue on the same edge, assert reset -> next cycle count=0, out_valid=0, credit_out=0. A subsequent single write of 7 -> out_data=7 with count=1.
